pig_turn_ctrl: RTL and testbench

- Turn and score controller for the electronic Pig game; sits directly downstream of the dice roller.
- Drives the roller's en_roll while the player holds the roll button and samples the settled 1–6 roll value.
- Applies Pig rules: a 1 busts the turn; 2–6 accumulate; hold banks the turn total.
- Tracks two players' scores and the active player, and declares a winner.

---
 rtl/pig_turn_ctrl_if.sv | 32 +++
 rtl/pig_turn_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pig_turn_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pig_turn_ctrl_if.sv
// Signal bundle between the Pig turn controller and the player buttons / dice roller.
// The master side drives the buttons and roll value. The slave side is the controller.
interface pig_turn_ctrl_if #(
    parameter int SCORE_W = 8
) ();
    logic               new_game;
    logic               roll_btn;
    logic               hold_btn;
    logic [3:0]         roll;
    logic               en_roll;
    logic               cur_player;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [SCORE_W-1:0] turn_total;
    logic [3:0]         last_roll;
    logic               bust;
    logic               roll_err;
    logic               game_over;
    logic               winner;

    modport master (
        output new_game, roll_btn, hold_btn, roll,
        input  en_roll, cur_player, p1_score, p2_score, turn_total, last_roll,
               bust, roll_err, game_over, winner
    );

    modport slave (
        input  new_game, roll_btn, hold_btn, roll,
        output en_roll, cur_player, p1_score, p2_score, turn_total, last_roll,
               bust, roll_err, game_over, winner
    );
endinterface

// File: rtl/pig_turn_ctrl.sv
// Turn and score controller for two-player Pig. It gates the dice roller and samples the settled roll.
// It applies bust, accumulate and bank rules, and holds the game in WIN until a new game starts.
module pig_turn_ctrl #(
    parameter int WIN_SCORE = 100,
    parameter int SCORE_W   = 8
) (
    input  logic           clock,
    input  logic           reset,
    pig_turn_ctrl_if.slave bus
);
    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_SPIN = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_BANK = 3'd3;
    localparam logic [2:0] ST_WIN  = 3'd4;

    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [SCORE_W:0]   WIN_THR    = (SCORE_W+1)'(WIN_SCORE);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SCORE_W]) begin
            sat_add = {SCORE_W{1'b1}};
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    logic [2:0]         r_state;
    logic               r_en_roll;
    logic               r_player;
    logic [SCORE_W-1:0] r_p1;
    logic [SCORE_W-1:0] r_p2;
    logic [SCORE_W-1:0] r_tt;
    logic [3:0]         r_last;
    logic               r_bust;
    logic               r_err;
    logic               r_over;
    logic               r_winner;

    logic [2:0]         w_state_nxt;
    logic               w_player_nxt;
    logic [SCORE_W-1:0] w_p1_nxt;
    logic [SCORE_W-1:0] w_p2_nxt;
    logic [SCORE_W-1:0] w_tt_nxt;
    logic [3:0]         w_last_nxt;
    logic               w_bust_nxt;
    logic               w_err_nxt;
    logic               w_winner_nxt;
    logic [SCORE_W-1:0] w_active;
    logic [SCORE_W:0]   w_bank_sum;
    logic [SCORE_W-1:0] w_bank_clip;

    // Banking arithmetic. The threshold uses the unclipped sum.
    always_comb begin
        if (r_player) begin
            w_active = r_p2;
        end else begin
            w_active = r_p1;
        end
        w_bank_sum  = {1'b0, w_active} + {1'b0, r_tt};
        w_bank_clip = sat_add(w_active, r_tt);
    end

    // Turn FSM next-state and next-value logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_player_nxt = r_player;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_tt_nxt     = r_tt;
        w_last_nxt   = r_last;
        w_bust_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_winner_nxt = r_winner;
        case (r_state)
            ST_WAIT: begin
                if (bus.roll_btn) begin
                    w_state_nxt = ST_SPIN;
                end else if (bus.hold_btn && (r_tt != SCORE_ZERO)) begin
                    w_state_nxt = ST_BANK;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_SPIN: begin
                if (bus.roll_btn) begin
                    w_state_nxt = ST_SPIN;
                end else begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_last_nxt  = bus.roll;
                w_state_nxt = ST_WAIT;
                if (bus.roll == 4'd1) begin
                    w_tt_nxt     = SCORE_ZERO;
                    w_player_nxt = ~r_player;
                    w_bust_nxt   = 1'b1;
                end else if ((bus.roll >= 4'd2) && (bus.roll <= 4'd6)) begin
                    w_tt_nxt = sat_add(r_tt, SCORE_W'(bus.roll));
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_BANK: begin
                w_tt_nxt = SCORE_ZERO;
                if (r_player) begin
                    w_p2_nxt = w_bank_clip;
                end else begin
                    w_p1_nxt = w_bank_clip;
                end
                if (w_bank_sum >= WIN_THR) begin
                    w_winner_nxt = r_player;
                    w_state_nxt  = ST_WIN;
                end else begin
                    w_player_nxt = ~r_player;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WIN: begin
                w_state_nxt = ST_WIN;
            end
            default: begin
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    // State and output registers. The asynchronous reset and the new_game clear use the same values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_WAIT;
            r_en_roll <= 1'b0;
            r_player  <= 1'b0;
            r_p1      <= SCORE_ZERO;
            r_p2      <= SCORE_ZERO;
            r_tt      <= SCORE_ZERO;
            r_last    <= 4'd0;
            r_bust    <= 1'b0;
            r_err     <= 1'b0;
            r_over    <= 1'b0;
            r_winner  <= 1'b0;
        end else if (bus.new_game) begin
            r_state   <= ST_WAIT;
            r_en_roll <= 1'b0;
            r_player  <= 1'b0;
            r_p1      <= SCORE_ZERO;
            r_p2      <= SCORE_ZERO;
            r_tt      <= SCORE_ZERO;
            r_last    <= 4'd0;
            r_bust    <= 1'b0;
            r_err     <= 1'b0;
            r_over    <= 1'b0;
            r_winner  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_en_roll <= (w_state_nxt == ST_SPIN);
            r_player  <= w_player_nxt;
            r_p1      <= w_p1_nxt;
            r_p2      <= w_p2_nxt;
            r_tt      <= w_tt_nxt;
            r_last    <= w_last_nxt;
            r_bust    <= w_bust_nxt;
            r_err     <= w_err_nxt;
            r_over    <= (w_state_nxt == ST_WIN);
            r_winner  <= w_winner_nxt;
        end
    end

    assign bus.en_roll    = r_en_roll;
    assign bus.cur_player = r_player;
    assign bus.p1_score   = r_p1;
    assign bus.p2_score   = r_p2;
    assign bus.turn_total = r_tt;
    assign bus.last_roll  = r_last;
    assign bus.bust       = r_bust;
    assign bus.roll_err   = r_err;
    assign bus.game_over  = r_over;
    assign bus.winner     = r_winner;
endmodule

// File: tb/tb_pig_turn_ctrl.sv
// Self-checking bench for pig_turn_ctrl. Directed scenarios and a randomized game are checked against a turn-level Pig model.
module tb_pig_turn_ctrl;
    localparam int SCORE_W   = 8;
    localparam int WIN_SCORE = 100;
    localparam int SMAX      = 255;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pig_turn_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    pig_turn_ctrl #(.WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: one update per completed roll or hold.
    int m_score[2];
    int m_player, m_tt, m_last, m_winner;
    bit m_over, m_bust, m_err;

    task automatic model_clear();
        m_score[0] = 0; m_score[1] = 0;
        m_player = 0; m_tt = 0; m_last = 0; m_winner = 0;
        m_over = 1'b0; m_bust = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_roll(input int v);
        m_bust = 1'b0; m_err = 1'b0;
        if (!m_over) begin
            m_last = v;
            if (v == 1) begin
                m_tt = 0; m_player = 1 - m_player; m_bust = 1'b1;
            end else if (v >= 2 && v <= 6) begin
                m_tt = (m_tt + v > SMAX) ? SMAX : m_tt + v;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic model_hold();
        int sum;
        m_bust = 1'b0; m_err = 1'b0;
        if (!m_over && m_tt != 0) begin
            sum = m_score[m_player] + m_tt;
            m_score[m_player] = (sum > SMAX) ? SMAX : sum;
            m_tt = 0;
            if (sum >= WIN_SCORE) begin
                m_over = 1'b1; m_winner = m_player;
            end else begin
                m_player = 1 - m_player;
            end
        end
    endtask

    // Stimulus helpers. Each one starts and ends on a falling edge.
    task automatic do_roll(input int spin, input int v);
        bus.roll = 4'(v);
        bus.roll_btn = 1'b1;
        repeat (spin) @(negedge clock);
        bus.roll_btn = 1'b0;
        repeat (2) @(negedge clock);
        model_roll(v);
    endtask

    task automatic do_hold();
        bus.hold_btn = 1'b1;
        @(negedge clock);
        bus.hold_btn = 1'b0;
        @(negedge clock);
        model_hold();
    endtask

    task automatic do_new_game();
        bus.roll_btn = 1'b0; bus.hold_btn = 1'b0;
        bus.new_game = 1'b1;
        @(negedge clock);
        bus.new_game = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        outs = {bus.en_roll, bus.cur_player, bus.p1_score, bus.p2_score, bus.turn_total,
                bus.last_roll, bus.bust, bus.roll_err, bus.game_over, bus.winner};
        n_checks++;
        if (outs !== 40'd0) begin
            n_fail++; $display("FAIL reset_outs got=%h exp=0", outs);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus.en_roll !== 1'b0) begin
                n_fail++; $display("FAIL reset_idle_en_roll cyc=%0d got=%b exp=0", i, bus.en_roll);
            end
        end
    endtask

    task automatic test_roll_basic();
        bus.roll = 4'd4;
        bus.roll_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus.en_roll !== 1'b1) begin
                n_fail++; $display("FAIL spin_en_roll cyc=%0d got=%b exp=1", i, bus.en_roll);
            end
        end
        bus.roll_btn = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.en_roll !== 1'b0 || bus.turn_total !== 8'd0) begin
            n_fail++; $display("FAIL eval_cycle got en=%b tt=%0d exp en=0 tt=0", bus.en_roll, bus.turn_total);
        end
        @(negedge clock);
        model_roll(4);
        n_checks++;
        if (bus.turn_total !== 8'(m_tt) || bus.last_roll !== 4'(m_last) || bus.cur_player !== 1'(m_player)) begin
            n_fail++; $display("FAIL roll4 got tt=%0d last=%0d pl=%b exp tt=%0d last=%0d pl=%0d",
                               bus.turn_total, bus.last_roll, bus.cur_player, m_tt, m_last, m_player);
        end
    endtask

    task automatic test_bust();
        do_new_game();
        do_roll(2, 4);
        do_roll(3, 5);
        n_checks++;
        if (bus.turn_total !== 8'(m_tt)) begin
            n_fail++; $display("FAIL tt9 got=%0d exp=%0d", bus.turn_total, m_tt);
        end
        do_roll(2, 1);
        n_checks++;
        if (bus.bust !== 1'b1 || bus.roll_err !== 1'b0 || bus.turn_total !== 8'd0 ||
            bus.cur_player !== 1'(m_player) || bus.p1_score !== 8'(m_score[0])) begin
            n_fail++; $display("FAIL bust got b=%b e=%b tt=%0d pl=%b p1=%0d exp b=1 e=0 tt=0 pl=%0d p1=%0d",
                               bus.bust, bus.roll_err, bus.turn_total, bus.cur_player, bus.p1_score, m_player, m_score[0]);
        end
        @(negedge clock);
        n_checks++;
        if (bus.bust !== 1'b0) begin
            n_fail++; $display("FAIL bust_pulse got=%b exp=0", bus.bust);
        end
    endtask

    task automatic test_hold_zero_and_both();
        do_hold();
        n_checks++;
        if (bus.cur_player !== 1'b1 || bus.p1_score !== 8'(m_score[0]) || bus.p2_score !== 8'(m_score[1])) begin
            n_fail++; $display("FAIL hold_zero got pl=%b p1=%0d p2=%0d exp pl=1 p1=%0d p2=%0d",
                               bus.cur_player, bus.p1_score, bus.p2_score, m_score[0], m_score[1]);
        end
        do_roll(1, 3);
        bus.roll = 4'd5;
        bus.roll_btn = 1'b1; bus.hold_btn = 1'b1;
        @(negedge clock);
        bus.hold_btn = 1'b0;
        n_checks++;
        if (bus.en_roll !== 1'b1) begin
            n_fail++; $display("FAIL both_btn_spin got=%b exp=1", bus.en_roll);
        end
        @(negedge clock);
        bus.roll_btn = 1'b0;
        repeat (2) @(negedge clock);
        model_roll(5);
        n_checks++;
        if (bus.turn_total !== 8'(m_tt) || bus.cur_player !== 1'(m_player) || bus.p2_score !== 8'(m_score[1])) begin
            n_fail++; $display("FAIL both_btn_result got tt=%0d pl=%b p2=%0d exp tt=%0d pl=%0d p2=%0d",
                               bus.turn_total, bus.cur_player, bus.p2_score, m_tt, m_player, m_score[1]);
        end
    endtask

    task automatic test_roll_err();
        do_roll(2, 7);
        n_checks++;
        if (bus.roll_err !== 1'b1 || bus.bust !== 1'b0 || bus.turn_total !== 8'(m_tt) || bus.last_roll !== 4'd7) begin
            n_fail++; $display("FAIL roll_err got e=%b b=%b tt=%0d last=%0d exp e=1 b=0 tt=%0d last=7",
                               bus.roll_err, bus.bust, bus.turn_total, bus.last_roll, m_tt);
        end
        @(negedge clock);
        n_checks++;
        if (bus.roll_err !== 1'b0) begin
            n_fail++; $display("FAIL roll_err_pulse got=%b exp=0", bus.roll_err);
        end
    endtask

    task automatic test_win();
        logic [39:0] outs;
        do_new_game();
        for (int i = 0; i < 15; i++) do_roll(1, 6);
        do_hold();
        do_roll(1, 1);
        do_roll(1, 6);
        do_roll(2, 6);
        n_checks++;
        if (bus.p1_score !== 8'd90 || bus.turn_total !== 8'd12 || bus.cur_player !== 1'b0) begin
            n_fail++; $display("FAIL win_setup got p1=%0d tt=%0d pl=%b exp p1=90 tt=12 pl=0",
                               bus.p1_score, bus.turn_total, bus.cur_player);
        end
        do_hold();
        n_checks++;
        if (bus.p1_score !== 8'(m_score[0]) || bus.game_over !== 1'b1 || bus.winner !== 1'b0 ||
            bus.cur_player !== 1'b0 || bus.p2_score !== 8'(m_score[1]) || bus.turn_total !== 8'd0) begin
            n_fail++; $display("FAIL win got p1=%0d over=%b w=%b pl=%b p2=%0d tt=%0d exp p1=%0d over=1 w=0 pl=0 p2=%0d tt=0",
                               bus.p1_score, bus.game_over, bus.winner, bus.cur_player, bus.p2_score, bus.turn_total,
                               m_score[0], m_score[1]);
        end
        bus.roll_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus.en_roll !== 1'b0) begin
                n_fail++; $display("FAIL win_en_roll cyc=%0d got=%b exp=0", i, bus.en_roll);
            end
        end
        bus.roll_btn = 1'b0;
        do_new_game();
        outs = {bus.en_roll, bus.cur_player, bus.p1_score, bus.p2_score, bus.turn_total,
                bus.last_roll, bus.bust, bus.roll_err, bus.game_over, bus.winner};
        n_checks++;
        if (outs !== 40'd0) begin
            n_fail++; $display("FAIL new_game_clear got=%h exp=0", outs);
        end
    endtask

    task automatic test_reset_mid_spin();
        do_new_game();
        do_roll(1, 5);
        do_hold();
        bus.roll = 4'd6;
        bus.roll_btn = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.en_roll !== 1'b1 || bus.p1_score !== 8'd5) begin
            n_fail++; $display("FAIL pre_reset got en=%b p1=%0d exp en=1 p1=5", bus.en_roll, bus.p1_score);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.en_roll !== 1'b0 || bus.p1_score !== 8'd0 || bus.turn_total !== 8'd0) begin
            n_fail++; $display("FAIL async_reset got en=%b p1=%0d tt=%0d exp 0 0 0", bus.en_roll, bus.p1_score, bus.turn_total);
        end
        bus.roll_btn = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.turn_total !== 8'd0 || bus.last_roll !== 4'd0 || bus.p1_score !== 8'd0 || bus.en_roll !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got tt=%0d last=%0d p1=%0d en=%b exp all 0",
                               bus.turn_total, bus.last_roll, bus.p1_score, bus.en_roll);
        end
    endtask

    task automatic test_random();
        int v;
        do_new_game();
        for (int it = 0; it < 200; it++) begin
            if (m_over) do_new_game();
            if ($urandom_range(0, 9) < 7) begin
                v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
                do_roll(int'($urandom_range(1, 4)), v);
            end else begin
                do_hold();
            end
            n_checks++;
            if (bus.p1_score !== 8'(m_score[0]) || bus.p2_score !== 8'(m_score[1]) ||
                bus.turn_total !== 8'(m_tt) || bus.cur_player !== 1'(m_player) ||
                bus.last_roll !== 4'(m_last) || bus.game_over !== m_over ||
                (m_over && bus.winner !== 1'(m_winner)) ||
                bus.bust !== m_bust || bus.roll_err !== m_err) begin
                n_fail++;
                $display("FAIL rnd it=%0d got p1=%0d p2=%0d tt=%0d pl=%b last=%0d ov=%b w=%b b=%b e=%b exp p1=%0d p2=%0d tt=%0d pl=%0d last=%0d ov=%b w=%0d b=%b e=%b",
                         it, bus.p1_score, bus.p2_score, bus.turn_total, bus.cur_player, bus.last_roll,
                         bus.game_over, bus.winner, bus.bust, bus.roll_err,
                         m_score[0], m_score[1], m_tt, m_player, m_last, m_over, m_winner, m_bust, m_err);
            end
        end
    endtask

    initial begin
        bus.new_game = 1'b0; bus.roll_btn = 1'b0; bus.hold_btn = 1'b0; bus.roll = 4'd0;
        model_clear();
        test_reset();
        test_roll_basic();
        test_bust();
        test_hold_zero_and_both();
        test_roll_err();
        test_win();
        test_reset_mid_spin();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
